// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: E/M destination scoreboard,
// mult/div busy counter and a running count of stall cycles.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  d_dst,
    input  logic [1:0]  d_tnew,
    input  logic        d_md_use,
    input  logic        d_md_start,
    input  logic        d_md_div,
    output logic        stall,
    output logic        flush_e,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    logic [4:0]       e_dst;
    logic [4:0]       m_dst;
    logic [1:0]       e_tnew;
    logic [1:0]       m_tnew;
    logic [CNT_W-1:0] busy_cnt;
    logic             hazard_rs;
    logic             hazard_rt;
    logic             md_stall;

    // W-stage writers are already forwardable, so only E and M are checked.
    always_comb begin
        hazard_rs = (d_rs != 5'd0) &&
                    (((e_dst == d_rs) && (e_tnew > d_tuse_rs)) ||
                     ((m_dst == d_rs) && (m_tnew > d_tuse_rs)));
        hazard_rt = (d_rt != 5'd0) &&
                    (((e_dst == d_rt) && (e_tnew > d_tuse_rt)) ||
                     ((m_dst == d_rt) && (m_tnew > d_tuse_rt)));
        md_busy   = (busy_cnt != '0);
        md_stall  = d_md_use && md_busy;
        stall     = hazard_rs || hazard_rt || md_stall;
        flush_e   = stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_dst     <= 5'd0;
            e_tnew    <= 2'd0;
            m_dst     <= 5'd0;
            m_tnew    <= 2'd0;
            busy_cnt  <= '0;
            stall_cnt <= 32'd0;
        end else begin
            m_dst  <= e_dst;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            if (stall) begin
                e_dst  <= 5'd0;
                e_tnew <= 2'd0;
            end else begin
                e_dst  <= d_dst;
                e_tnew <= d_tnew;
            end

            // A stalled start never loads; a start while busy is always stalled.
            if (!stall && d_md_start)
                busy_cnt <= d_md_div ? DIV_LD : MULT_LD;
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - 1'b1;

            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios followed by random
// D-stage traffic, compared against a cycle-indexed reference model.
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  d_rs, d_rt, d_dst;
    logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        d_md_use, d_md_start, d_md_div;
    logic        stall, flush_e, md_busy;
    logic [31:0] stall_cnt;

    hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_md_use(d_md_use),
        .d_md_start(d_md_start), .d_md_div(d_md_div),
        .stall(stall), .flush_e(flush_e), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic [4:0] dst;
        int         tnew;
        longint     k;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wq[$];
    longint      cyc      = 0;
    longint      busy_end = -1;
    logic [31:0] m_cnt    = 0;
    int          tests    = 0;
    int          fails    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A writer issued at the edge ending cycle k sits in E during k+1 and M during
    // k+2; its remaining latency shrinks by one per cycle spent in the pipe.
    function automatic logic model_stall(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [1:0] tr, input logic [1:0] tt,
                                         input logic mu);
        logic h = 1'b0;
        foreach (wq[i]) begin
            longint age = cyc - wq[i].k - 1;
            int     rem;
            if (age >= 0 && age <= 1) begin
                rem = wq[i].tnew - int'(age);
                if (rem < 0) rem = 0;
                if (rs != 0 && wq[i].dst == rs && rem > int'(tr)) h = 1'b1;
                if (rt != 0 && wq[i].dst == rt && rem > int'(tt)) h = 1'b1;
            end
        end
        if (mu && cyc <= busy_end) h = 1'b1;
        return h;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall",     {31'd0, stall},   {31'd0, e.stall});
            check("flush_e",   {31'd0, flush_e}, {31'd0, e.stall});
            check("md_busy",   {31'd0, md_busy}, {31'd0, e.busy});
            check("stall_cnt", stall_cnt,        e.cnt);
        end
    end

    // One clock cycle: drive D, queue the model's expectation, advance the model.
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] tr, input logic [1:0] tt,
                        input logic [4:0] dst, input logic [1:0] tn,
                        input logic mu, input logic ms, input logic mdv,
                        output logic s_obs);
        exp_t e;
        logic es;
        rst = r; d_rs = rs; d_rt = rt; d_tuse_rs = tr; d_tuse_rt = tt;
        d_dst = dst; d_tnew = tn; d_md_use = mu; d_md_start = ms; d_md_div = mdv;
        es      = model_stall(rs, rt, tr, tt, mu);
        e.stall = es;
        e.busy  = (cyc <= busy_end);
        e.cnt   = m_cnt;
        exp_q.push_back(e);
        #1 s_obs = stall;
        @(posedge clk);
        #1;
        if (r) begin
            wq.delete();
            busy_end = -1;
            m_cnt    = 0;
        end else begin
            wr_t w;
            if (es) m_cnt = m_cnt + 32'd1;
            if (!es && ms) busy_end = cyc + (mdv ? DIV_N : MULT_N);
            w.dst  = es ? 5'd0 : dst;
            w.tnew = es ? 0 : int'(tn);
            w.k    = cyc;
            wq.push_back(w);
            if (wq.size() > 2) void'(wq.pop_front());
        end
        cyc++;
    endtask

    task automatic nop();
        logic s;
        step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s);
    endtask

    // Hold an instruction in D until the DUT lets it go; report cycles it stalled.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tr, input logic [1:0] tt,
                         input logic [4:0] dst, input logic [1:0] tn,
                         input logic mu, input logic ms, input logic mdv,
                         output int n);
        logic s;
        logic done = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(1'b0, rs, rt, tr, tt, dst, tn, mu, ms, mdv, s);
            if (s) n++;
            else   done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: got %0d stall cycles, required release within 40", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] c0;
        logic        s;
        logic [4:0]  r_rs, r_rt, r_dst;
        logic [1:0]  r_tr, r_tt, r_tn;
        logic        r_mu, r_ms, r_mdv;

        rst = 1'b1; d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3;
        d_dst = 0; d_tnew = 0; d_md_use = 0; d_md_start = 0; d_md_div = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // lw $1 then add rs=$1
        issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, n);
        issue(5'd1, 5'd0, 2'd1, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0, n);
        check("lw_add_stalls", n, 1);
        check("lw_add_cnt", stall_cnt, 1);
        nop(); nop();

        // lw $1 then beq, addu $1 then beq
        issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, n);
        issue(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, n);
        check("lw_beq_stalls", n, 2);
        nop(); nop();
        issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0, n);
        issue(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, n);
        check("addu_beq_stalls", n, 1);
        nop(); nop();

        // mult then mflo, div then mfhi
        issue(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, n);
        check("mult_no_stall", n, 0);
        issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, n);
        check("mflo_stalls", n, MULT_N);
        issue(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, n);
        issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, n);
        check("mfhi_stalls", n, DIV_N);
        nop(); nop();

        // $0 never hazards; W-stage writer never hazards
        issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, n);
        issue(5'd0, 5'd0, 2'd1, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0, n);
        check("zero_reg_stalls", n, 0);
        issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd2, 1'b0, 1'b0, 1'b0, n);
        nop(); nop();
        issue(5'd2, 5'd2, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, n);
        check("w_stage_stalls", n, 0);

        // stall and md together count once per cycle
        issue(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, n);
        nop();
        issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd2, 1'b0, 1'b0, 1'b0, n);
        c0 = stall_cnt;
        issue(5'd3, 5'd0, 2'd0, 2'd3, 5'd7, 2'd1, 1'b1, 1'b0, 1'b0, n);
        check("dual_stalls", n, 3);
        check("dual_cnt_delta", stall_cnt - c0, 3);

        // reset while div busy at count 6
        issue(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, n);
        repeat (4) nop();
        step(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, s);
        check("rst_md_busy", {31'd0, md_busy}, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b1, 1'b0, 1'b0, n);
        check("rst_mfhi_stalls", n, 0);

        // random traffic; a stalled instruction is usually held in D
        s = 1'b0;
        r_rs = 0; r_rt = 0; r_tr = 3; r_tt = 3; r_dst = 0; r_tn = 0;
        r_mu = 0; r_ms = 0; r_mdv = 0;
        for (int i = 0; i < 500; i++) begin
            logic r;
            r = ($urandom_range(0, 59) == 0);
            if (!(s && $urandom_range(0, 3) != 0)) begin
                r_rs  = 5'($urandom_range(0, 3));
                r_rt  = 5'($urandom_range(0, 3));
                r_tr  = 2'($urandom_range(0, 3));
                r_tt  = 2'($urandom_range(0, 3));
                r_dst = 5'($urandom_range(0, 3));
                r_tn  = 2'($urandom_range(0, 2));
                r_mu  = ($urandom_range(0, 3) == 0);
                r_ms  = r_mu && ($urandom_range(0, 1) == 1);
                r_mdv = ($urandom_range(0, 1) == 1);
            end
            step(r, r_rs, r_rt, r_tr, r_tt, r_dst, r_tn, r_mu, r_ms, r_mdv, s);
        end

        rst = 1'b0; d_md_use = 0; d_md_start = 0;
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
